// File: rtl/i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// i2s_dac_tx
//   I2S (Philips) master transmitter feeding the WM8731 DAC input. Accepts
//   stereo pairs from the FIR stage over valid/ready, parks one pair in a
//   holding register, and shifts each frame out MSB first with the standard
//   one-BCLK delay after the DACLRC edge. BCLK and DACLRC are derived from
//   clk_i by integer division.
//
// Parameters
//   DATA_W   sample width per channel (two's complement, passed bit-exact)
//   SLOT_W   BCLK periods per channel slot (SLOT_W >= DATA_W)
//   BCLK_DIV clk_i cycles per BCLK half-period (BCLK_DIV >= 2)
//
// Ports
//   clk_i, rst_ni       system clock, async active-low reset
//   en_i                serializer enable (holding register unaffected)
//   l_data_i, r_data_i  stereo sample pair
//   valid_i, ready_o    pair handshake; ready_o = holding register empty
//   bclk_o, lrck_o      bit clock / DACLRC (0 = left, 1 = right)
//   dacdat_o            serial data, changes on BCLK falling edges only
//   underrun_o          1-cycle pulse when a frame starts with no pair held
// -----------------------------------------------------------------------------
module i2s_dac_tx #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [DATA_W-1:0] l_data_i,
  input  logic [DATA_W-1:0] r_data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              bclk_o,
  output logic              lrck_o,
  output logic              dacdat_o,
  output logic              underrun_o
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int DIV_W   = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_W);

  // Holding register
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic              hold_full_q, hold_full_d;

  // Clock generation and framing
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               bclk_q, bclk_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;   // MSB is the next bit to emit
  logic               lrck_q, lrck_d;
  logic               dacdat_q, dacdat_d;
  logic               underrun_q, underrun_d;

  logic               wrap, fall_tick, transfer;
  logic [BIT_W-1:0]   bit_nxt;
  logic [SLOT_W-1:0]  slot_l, slot_r;

  // Left-justify each sample in its slot; trailing pad bits are zero.
  always_comb begin
    slot_l = '0;
    slot_r = '0;
    slot_l[SLOT_W-1 -: DATA_W] = hold_l_q;
    slot_r[SLOT_W-1 -: DATA_W] = hold_r_q;
  end

  assign wrap      = (div_cnt_q == DIV_LAST);
  assign fall_tick = wrap && bclk_q;
  assign bit_nxt   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
  // Only possible while empty, so it never collides with a frame-load clear.
  assign transfer  = valid_i && !hold_full_q;

  always_comb begin
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    div_cnt_d   = div_cnt_q;
    bclk_d      = bclk_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    lrck_d      = lrck_q;
    dacdat_d    = dacdat_q;
    underrun_d  = 1'b0;

    if (transfer) begin
      hold_l_d    = l_data_i;
      hold_r_d    = r_data_i;
      hold_full_d = 1'b1;
    end

    if (!en_i) begin
      // Park everything in its post-reset state so re-enable replays the
      // exact reset timing; the held pair survives.
      div_cnt_d = '0;
      bclk_d    = 1'b0;
      bit_cnt_d = BIT_LAST;
      shift_d   = '0;
      lrck_d    = 1'b0;
      dacdat_d  = 1'b0;
    end else begin
      div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
      if (wrap) bclk_d = !bclk_q;

      if (fall_tick) begin
        bit_cnt_d = bit_nxt;
        lrck_d    = (bit_nxt >= SLOT_B);
        // Emitting the shifter MSB before loading gives the one-BCLK delay:
        // at bit 0 the last bit of the previous frame goes out.
        dacdat_d  = shift_q[FRAME_W-1];
        if (bit_nxt == '0) begin
          if (hold_full_q) begin
            shift_d     = {slot_l, slot_r};
            hold_full_d = 1'b0;
          end else begin
            shift_d     = '0;
            underrun_d  = 1'b1;
          end
        end else begin
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= BIT_LAST;
      shift_q     <= '0;
      lrck_q      <= 1'b0;
      dacdat_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      lrck_q      <= lrck_d;
      dacdat_q    <= dacdat_d;
      underrun_q  <= underrun_d;
    end
  end

  assign ready_o    = !hold_full_q;
  assign bclk_o     = bclk_q;
  assign lrck_o     = lrck_q;
  assign dacdat_o   = dacdat_q;
  assign underrun_o = underrun_q;

endmodule
